// File: rtl/spi_master_pkg.sv
// Shared types and constants for the MMIO SPI master: engine states,
// TX FIFO entry layout and the per-transfer bit count.
package spi_master_pkg;

  localparam int BITS_PER_XFER = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    NEXT
  } spi_state_e;

  typedef struct packed {
    logic       ignore;
    logic [7:0] data;
  } tx_entry_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with a combinational head. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_master_mmio.sv
// MMIO SPI master (mode 0, MSB first) with TX/RX byte FIFOs.
// Define SPI_RX_OVERFLOW_EN to add the sticky spi_rx_ovf status flag.
module spi_master_mmio
  import spi_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_wr,
  input  logic       spi_rd,
  input  logic       spi_addr,
  input  logic [7:0] spi_din,
  input  logic       spi_ignore_response,
  output logic [7:0] spi_dout,
  output logic       spi_buffer_full,
  output logic       spi_buffer_empty,
  output logic       spi_data_avail,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
`ifdef SPI_RX_OVERFLOW_EN
  ,
  output logic       spi_rx_ovf
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [2:0]    BIT_LAST = 3'(BITS_PER_XFER - 1);

  spi_state_e    state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          ignore_q, ignore_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          div_done;

  tx_entry_t tx_din, tx_head;
  logic      tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] rx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty, rx_keep;

  assign tx_din  = '{ignore: spi_ignore_response, data: spi_din};
  assign tx_push = spi_wr && !tx_full;
  assign rx_pop  = spi_rd && !spi_addr && !rx_empty;

  spi_sync_fifo #(.WIDTH($bits(tx_entry_t)), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_din),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift_q),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    ignore_d   = ignore_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_pop     = 1'b0;
    rx_keep    = 1'b0;
    div_done   = (div_cnt_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        tx_pop    = !tx_empty;
      end
      SETUP, LOW: begin
        if (div_done) begin
          div_cnt_d = '0;
          sck_d     = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (div_cnt_q == '0) rx_shift_d = {rx_shift_q[6:0], miso};
        if (div_done) begin
          div_cnt_d = '0;
          sck_d     = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = NEXT;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            mosi_d    = shift_q[6];
            state_d   = LOW;
          end
        end
      end
      NEXT: begin
        div_cnt_d = '0;
        rx_keep   = !ignore_q;
        tx_pop    = !tx_empty;
        if (tx_empty) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading the next entry from IDLE or NEXT; from NEXT cs_n simply stays low.
    if (tx_pop) begin
      shift_d   = tx_head.data;
      ignore_d  = tx_head.ignore;
      mosi_d    = tx_head.data[7];
      cs_n_d    = 1'b0;
      bit_cnt_d = '0;
      state_d   = SETUP;
    end
  end

  assign rx_push = rx_keep && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      ignore_q   <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      ignore_q   <= ignore_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign spi_dout         = rx_empty ? 8'h00 : rx_head;
  assign spi_buffer_full  = tx_full;
  assign spi_buffer_empty = tx_empty && (state_q == IDLE);
  assign spi_data_avail   = !rx_empty;
  assign sck              = sck_q;
  assign mosi             = mosi_q;
  assign cs_n             = cs_n_q;

`ifdef SPI_RX_OVERFLOW_EN
  logic rx_ovf_q, rx_ovf_d;
  logic rx_drop;

  // Set beats clear when a drop and a status read coincide.
  always_comb begin
    rx_drop  = rx_keep && !rx_push;
    rx_ovf_d = rx_ovf_q;
    if (spi_rd && spi_addr) rx_ovf_d = 1'b0;
    if (rx_drop)            rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rx_ovf_q <= 1'b0;
    else     rx_ovf_q <= rx_ovf_d;
  end

  assign spi_rx_ovf = rx_ovf_q;
`else
  // Without the flag a byte arriving at a full RX FIFO is dropped silently.
`endif

endmodule

// File: tb/tb_spi_master_mmio.sv
// Scoreboard bench for spi_master_mmio in loopback (miso = mosi), CLK_DIV=4.
// Covers reset, loopback, ignore, back-to-back, TX full, mid-transfer reset, RX overflow.
module tb_spi_master_mmio;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_wr = 1'b0;
  logic       stim_rd = 1'b0;
  logic       mon_rd = 1'b0;
  logic       spi_rd;
  logic       spi_addr = 1'b0;
  logic [7:0] spi_din = 8'h00;
  logic       spi_ignore_response = 1'b0;
  logic [7:0] spi_dout;
  logic       spi_buffer_full, spi_buffer_empty, spi_data_avail;
  logic       sck, mosi, miso, cs_n;
`ifdef SPI_RX_OVERFLOW_EN
  logic       spi_rx_ovf;
`endif

  assign spi_rd = stim_rd | mon_rd;
  assign miso   = mosi;

  always #5 clk = ~clk;

  spi_master_mmio #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .spi_wr              (spi_wr),
    .spi_rd              (spi_rd),
    .spi_addr            (spi_addr),
    .spi_din             (spi_din),
    .spi_ignore_response (spi_ignore_response),
    .spi_dout            (spi_dout),
    .spi_buffer_full     (spi_buffer_full),
    .spi_buffer_empty    (spi_buffer_empty),
    .spi_data_avail      (spi_data_avail),
    .sck                 (sck),
    .mosi                (mosi),
    .miso                (miso),
    .cs_n                (cs_n)
`ifdef SPI_RX_OVERFLOW_EN
    ,
    .spi_rx_ovf          (spi_rx_ovf)
`endif
  );

  int         total = 0;
  int         bad = 0;
  int         tx_seen = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // RX monitor: pops the RX FIFO whenever data is presented and scores it.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_rd) begin
        mon_rd = 1'b0;
      end else if (mon_en && spi_data_avail) begin
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rx_unexpected: got 0x%0h, want no byte", spi_dout);
        end else begin
          checkOutput("rx_byte", spi_dout, exp_rx.pop_front());
        end
        mon_rd = 1'b1;
      end
    end
  end

  // TX monitor: rebuilds each byte from mosi at sck rising edges.
  initial begin
    logic [7:0] tx_sh;
    int         nbits;
    logic       sck_prev;
    tx_sh    = 8'h00;
    nbits    = 0;
    sck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nbits = 0;
      end else if (sck && !sck_prev) begin
        tx_sh = {tx_sh[6:0], mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          tx_seen++;
          if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL tx_unexpected: got 0x%0h, want no byte", tx_sh);
          end else begin
            checkOutput("tx_byte", tx_sh, exp_tx.pop_front());
          end
        end
      end
      sck_prev = sck;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] d, input logic ign, input bit accept);
    spi_wr              = 1'b1;
    spi_din             = d;
    spi_ignore_response = ign;
    if (accept) begin
      exp_tx.push_back(d);
      if (!ign && mon_en) exp_rx.push_back(d);
    end
    @(negedge clk);
    spi_wr              = 1'b0;
    spi_ignore_response = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int max_cycles);
    int n = 0;
    while (!spi_buffer_empty && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, spi_buffer_empty, 1'b1);
  endtask

  initial begin
    int   n, rises;
    logic prev, low_seen, gap;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_sck", sck, 1'b0);
    checkOutput("rst_mosi", mosi, 1'b0);
    checkOutput("rst_cs_n", cs_n, 1'b1);
    checkOutput("rst_dout", spi_dout, 8'h00);
    checkOutput("rst_full", spi_buffer_full, 1'b0);
    checkOutput("rst_empty", spi_buffer_empty, 1'b1);
    checkOutput("rst_avail", spi_data_avail, 1'b0);
`ifdef SPI_RX_OVERFLOW_EN
    checkOutput("rst_ovf", spi_rx_ovf, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single loopback byte, checked directly.
    applyStimulus(8'hA5, 1'b0, 1'b1);
    n = 0; rises = 0; prev = sck; low_seen = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!cs_n) low_seen = 1'b1;
      if (sck && !prev) rises++;
      prev = sck;
      if (low_seen && cs_n) break;
    end
    checkOutput("a5_cs_low", low_seen, 1'b1);
    checkOutput("a5_period", n, 66);
    checkOutput("a5_sck_rises", rises, 8);
    checkOutput("a5_avail", spi_data_avail, 1'b1);
    checkOutput("a5_dout", spi_dout, 8'hA5);
    spi_addr = 1'b1; stim_rd = 1'b1;
    @(negedge clk);
    stim_rd = 1'b0; spi_addr = 1'b0;
    checkOutput("status_rd_keeps_rx", spi_data_avail, 1'b1);
    stim_rd = 1'b1;
    checkOutput("rd_dout_same_cycle", spi_dout, 8'hA5);
    @(negedge clk);
    stim_rd = 1'b0;
    checkOutput("rd_pop_avail", spi_data_avail, 1'b0);
    checkOutput("rd_pop_dout", spi_dout, 8'h00);

    // Ignore-response byte still goes out on mosi but is not captured.
    applyStimulus(8'h3C, 1'b1, 1'b1);
    waitIdle("ign_idle", 300);
    checkOutput("ign_avail", spi_data_avail, 1'b0);
    checkOutput("ign_tx_seen", tx_seen, 2);

    // Back-to-back bytes share one cs_n assertion.
    mon_en = 1'b1;
    applyStimulus(8'h01, 1'b0, 1'b1);
    applyStimulus(8'h02, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b0, 1'b1);
    n = 0; gap = 1'b0;
    while (!spi_buffer_empty && n < 400) begin
      @(negedge clk);
      n++;
      if (!spi_buffer_empty && cs_n) gap = 1'b1;
    end
    checkOutput("b2b_idle", spi_buffer_empty, 1'b1);
    checkOutput("b2b_no_cs_gap", gap, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("b2b_rx_drained", exp_rx.size(), 0);
    checkOutput("b2b_tx_seen", tx_seen, 5);

    // Ten writes while the engine is busy: one popped, eight queued, last dropped.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b0, i < 9);
      if (i == 7) checkOutput("txf_not_full_at_7", spi_buffer_full, 1'b0);
      if (i >= 8) checkOutput("txf_full", spi_buffer_full, 1'b1);
    end
    waitIdle("txf_idle", 1000);
    repeat (4) @(negedge clk);
    checkOutput("txf_rx_drained", exp_rx.size(), 0);
    checkOutput("txf_tx_drained", exp_tx.size(), 0);
    checkOutput("txf_tx_seen", tx_seen, 14);

    // Reset in the middle of a transfer, with a byte sitting in RX.
    mon_en = 1'b0;
    applyStimulus(8'h77, 1'b0, 1'b1);
    waitIdle("rstm_idle", 300);
    checkOutput("rstm_pre_avail", spi_data_avail, 1'b1);
    applyStimulus(8'h5A, 1'b0, 1'b1);
    n = 0; rises = 0; prev = sck;
    while (rises < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (sck && !prev) rises++;
      prev = sck;
    end
    checkOutput("rstm_rises", rises, 3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstm_cs_n", cs_n, 1'b1);
    checkOutput("rstm_sck", sck, 1'b0);
    checkOutput("rstm_empty", spi_buffer_empty, 1'b1);
    checkOutput("rstm_avail", spi_data_avail, 1'b0);
    checkOutput("rstm_dout", spi_dout, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    mon_en = 1'b1;
    applyStimulus(8'hC3, 1'b0, 1'b1);
    waitIdle("post_rst_idle", 300);
    repeat (4) @(negedge clk);
    checkOutput("post_rst_rx_drained", exp_rx.size(), 0);
    checkOutput("post_rst_tx_drained", exp_tx.size(), 0);
    checkOutput("post_rst_tx_seen", tx_seen, 16);
    mon_en = 1'b0;

    // Nine bytes with no reads: RX keeps the first eight.
    for (int i = 0; i < 9; i++) applyStimulus(8'(8'h80 + i), 1'b0, 1'b1);
    waitIdle("ovf_idle", 1000);
    checkOutput("ovf_tx_seen", tx_seen, 25);
    checkOutput("ovf_avail", spi_data_avail, 1'b1);
`ifdef SPI_RX_OVERFLOW_EN
    checkOutput("ovf_flag_set", spi_rx_ovf, 1'b1);
`endif
    spi_addr = 1'b1; stim_rd = 1'b1;
    @(negedge clk);
    stim_rd = 1'b0; spi_addr = 1'b0;
`ifdef SPI_RX_OVERFLOW_EN
    checkOutput("ovf_flag_clear", spi_rx_ovf, 1'b0);
`endif
    checkOutput("ovf_avail_after_status", spi_data_avail, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("ovf_rx_byte", spi_dout, 8'(8'h80 + i));
      stim_rd = 1'b1;
      @(negedge clk);
    end
    stim_rd = 1'b0;
    checkOutput("ovf_rx_empty", spi_data_avail, 1'b0);
    checkOutput("ovf_rx_dout_zero", spi_dout, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
